// File: rtl/nn_io_pkg.sv
// Shared types, state codes and helpers for the neural-network host I/O block.
package nn_io_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned STATE_W    = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_NRST    = 3'd1;
  localparam state_t ST_FILL    = 3'd2;
  localparam state_t ST_COMPUTE = 3'd3;
  localparam state_t ST_DONE    = 3'd4;
  localparam state_t ST_ERR     = 3'd5;

  // Ceiling log2; clog2(1) = 0, callers clamp to a minimum width of 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    if (v > 1) begin
      for (int unsigned x = v - 1; x > 0; x = x >> 1) begin
        r = r + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/nn_io_regfile.sv
// Small register file: one synchronous write port, one combinational read
// port, synchronous clear. Out-of-range writes are dropped, reads return 0.
module nn_io_regfile #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AW     = 1
) (
  input  logic              clk,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (clr_i) begin
        mem_q[i] <= '0;
      end else if (we_i && (32'(waddr_i) == i)) begin
        mem_q[i] <= wdata_i;
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    if (32'(raddr_i) < DEPTH) begin
      rdata_o = mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/nn_io_host.sv
// Host-side driver for one network instance: owns the input/output register
// files and sequences reset, input fill and compute with a timeout.
module nn_io_host
  import nn_io_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned N_IN    = 2,
  parameter int unsigned N_OUT   = 1,
  parameter int unsigned IN_AW   = 1,
  parameter int unsigned OUT_AW  = 1,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_we,
  input  logic [IN_AW-1:0]  host_waddr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [OUT_AW-1:0] host_raddr,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [OUT_AW:0]   out_cnt,
  output logic              net_rst,
  output logic              net_fill,
  output logic              net_req,
  input  logic              net_ack_fill,
  input  logic              net_ack,
  input  logic              net_in_trig,
  input  logic [IN_AW-1:0]  net_in_addr,
  output logic [DATA_W-1:0] net_in_data,
  input  logic              net_out_trig,
  input  logic [OUT_AW-1:0] net_out_addr,
  input  logic [DATA_W-1:0] net_out_data
);

  localparam int unsigned TW         = (clog2(TIMEOUT) > 0) ? clog2(TIMEOUT) : 1;
  localparam int unsigned CW         = OUT_AW + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(N_OUT);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic          busy_q, done_q, err_q;
  logic          net_rst_q, net_fill_q, net_req_q;
  logic          in_we_c, capture_c;
  logic          unused_in_trig;

  // The input read port is always live; the trigger only qualifies it on the network side.
  assign unused_in_trig = net_in_trig;

  assign in_we_c   = host_we && !busy_q;
  assign capture_c = ((state_q == ST_FILL) || (state_q == ST_COMPUTE)) &&
                     net_out_trig && (32'(net_out_addr) < N_OUT);

  always_comb begin
    state_d   = state_q;
    timer_d   = '0;
    out_cnt_d = out_cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_d = ST_NRST;
      end
      ST_NRST: begin
        state_d = ST_FILL;
      end
      ST_FILL: begin
        if (net_ack_fill) state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        timer_d = timer_q + TW'(1);
        // Ack wins over a timeout landing in the same cycle.
        if (net_ack) begin
          state_d = ST_DONE;
        end else if (timer_q == TIMER_LAST) begin
          state_d = ST_ERR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_NRST) begin
      out_cnt_d = '0;
    end else if (capture_c && (out_cnt_q < CNT_MAX)) begin
      out_cnt_d = out_cnt_q + CW'(1);
    end
  end

  // Outputs are registered images of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      out_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      net_rst_q  <= 1'b1;
      net_fill_q <= 1'b0;
      net_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      out_cnt_q  <= out_cnt_d;
      busy_q     <= (state_d == ST_NRST) || (state_d == ST_FILL) ||
                    (state_d == ST_COMPUTE);
      done_q     <= (state_d == ST_DONE);
      err_q      <= (state_d == ST_ERR);
      net_rst_q  <= (state_d == ST_NRST);
      net_fill_q <= (state_d == ST_FILL);
      net_req_q  <= (state_d == ST_COMPUTE);
    end
  end

  nn_io_regfile #(
    .DEPTH  (N_IN),
    .DATA_W (DATA_W),
    .AW     (IN_AW)
  ) u_in_mem (
    .clk     (clk),
    .clr_i   (rst),
    .we_i    (in_we_c),
    .waddr_i (host_waddr),
    .wdata_i (host_wdata),
    .raddr_i (net_in_addr),
    .rdata_o (net_in_data)
  );

  nn_io_regfile #(
    .DEPTH  (N_OUT),
    .DATA_W (DATA_W),
    .AW     (OUT_AW)
  ) u_out_mem (
    .clk     (clk),
    .clr_i   (rst),
    .we_i    (capture_c),
    .waddr_i (net_out_addr),
    .wdata_i (net_out_data),
    .raddr_i (host_raddr),
    .rdata_o (host_rdata)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign out_cnt  = out_cnt_q;
  assign net_rst  = net_rst_q;
  assign net_fill = net_fill_q;
  assign net_req  = net_req_q;

endmodule

// File: tb/tb_nn_io_host.sv
// Directed + randomized bench for nn_io_host with a behavioural network model.
module tb_nn_io_host;

  localparam int unsigned DW  = 8;
  localparam int unsigned NI  = 2;
  localparam int unsigned NO  = 1;
  localparam int unsigned IAW = 1;
  localparam int unsigned OAW = 1;
  localparam int unsigned TO  = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           host_we;
  logic [IAW-1:0] host_waddr;
  logic [DW-1:0]  host_wdata;
  logic [OAW-1:0] host_raddr;
  logic [DW-1:0]  host_rdata;
  logic           start;
  logic           busy, done, err;
  logic [OAW:0]   out_cnt;
  logic           net_rst, net_fill, net_req;
  logic           net_ack_fill, net_ack;
  logic           net_in_trig;
  logic [IAW-1:0] net_in_addr;
  logic [DW-1:0]  net_in_data;
  logic           net_out_trig;
  logic [OAW-1:0] net_out_addr;
  logic [DW-1:0]  net_out_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] in_ref  [NI];
  logic [DW-1:0] out_ref [NO];
  int            cnt_ref;

  always #5 clk = ~clk;

  nn_io_host #(
    .DATA_W (DW), .N_IN (NI), .N_OUT (NO),
    .IN_AW (IAW), .OUT_AW (OAW), .TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .host_we      (host_we),
    .host_waddr   (host_waddr),
    .host_wdata   (host_wdata),
    .host_raddr   (host_raddr),
    .host_rdata   (host_rdata),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .out_cnt      (out_cnt),
    .net_rst      (net_rst),
    .net_fill     (net_fill),
    .net_req      (net_req),
    .net_ack_fill (net_ack_fill),
    .net_ack      (net_ack),
    .net_in_trig  (net_in_trig),
    .net_in_addr  (net_in_addr),
    .net_in_data  (net_in_data),
    .net_out_trig (net_out_trig),
    .net_out_addr (net_out_addr),
    .net_out_data (net_out_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int a = 0; a < NI; a++) in_ref[a] = '0;
    for (int a = 0; a < NO; a++) out_ref[a] = '0;
    cnt_ref = 0;
  endtask

  task automatic host_load(input int a, input logic [DW-1:0] d);
    host_we = 1'b1; host_waddr = IAW'(a); host_wdata = d;
    step();
    host_we = 1'b0;
    if (a < NI) in_ref[a] = d;
  endtask

  // Every output slot reads back the model value; unmapped slots read 0.
  task automatic check_out_mem(input string tag);
    for (int a = 0; a < (1 << OAW); a++) begin
      host_raddr = OAW'(a);
      #1;
      check($sformatf("%s_rdata%0d", tag, a), 32'(host_rdata), (a < NO) ? 32'(out_ref[a]) : 32'd0);
    end
  endtask

  task automatic check_in_mem(input string tag);
    for (int a = 0; a < (1 << IAW); a++) begin
      net_in_addr = IAW'(a);
      #1;
      check($sformatf("%s_in%0d", tag, a), 32'(net_in_data), (a < NI) ? 32'(in_ref[a]) : 32'd0);
    end
  endtask

  // Start pulse, then one-cycle network reset, then fill.
  task automatic begin_run();
    start = 1'b1;
    step();
    start = 1'b0;
    cnt_ref = 0;
    check("nrst_high", 32'(net_rst), 32'd1);
    check("nrst_busy", 32'(busy), 32'd1);
    check("nrst_done_clr", 32'(done), 32'd0);
    check("nrst_err_clr", 32'(err), 32'd0);
    check("nrst_cnt_clr", 32'(out_cnt), 32'd0);
    step();
    check("nrst_one_cycle", 32'(net_rst), 32'd0);
    check("fill_high", 32'(net_fill), 32'd1);
  endtask

  // Network reads each input in a trigger cycle, then acks the fill.
  task automatic read_inputs();
    for (int a = 0; a < NI; a++) begin
      net_in_trig = 1'b1; net_in_addr = IAW'(a);
      #1;
      check($sformatf("in_data%0d", a), 32'(net_in_data), 32'(in_ref[a]));
      step();
    end
    net_in_trig = 1'b0;
    net_ack_fill = 1'b1;
    step();
    net_ack_fill = 1'b0;
    check("fill_drop", 32'(net_fill), 32'd0);
    check("req_high", 32'(net_req), 32'd1);
  endtask

  task automatic out_write(input int a, input logic [DW-1:0] d, input bit active);
    net_out_trig = 1'b1; net_out_addr = OAW'(a); net_out_data = d;
    step();
    net_out_trig = 1'b0;
    if (active && a < NO) begin
      out_ref[a] = d;
      if (cnt_ref < NO) cnt_ref++;
    end
  endtask

  task automatic finish_ok(input string tag);
    net_ack = 1'b1;
    step();
    net_ack = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_req_low"}, 32'(net_req), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_cnt"}, 32'(out_cnt), 32'(cnt_ref));
    check_out_mem(tag);
  endtask

  task automatic random_run(input int r);
    int k;
    host_load(0, DW'($urandom));
    host_load(1, DW'($urandom));
    begin_run();
    read_inputs();
    out_write(0, DW'($urandom), 1'b1);
    k = int'($urandom_range(0, TO - 2));
    for (int i = 0; i < k; i++) step();
    finish_ok($sformatf("rand%0d", r));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; host_we = 1'b0; host_waddr = '0; host_wdata = '0;
    host_raddr = '0; net_ack_fill = 1'b0; net_ack = 1'b0; net_in_trig = 1'b0;
    net_in_addr = '0; net_out_trig = 1'b0; net_out_addr = '0; net_out_data = '0;
    clear_model();

    // Reset state
    step(); step();
    check("rst_net_rst", 32'(net_rst), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cnt", 32'(out_cnt), 32'd0);
    check("rst_fill", 32'(net_fill), 32'd0);
    check("rst_req", 32'(net_req), 32'd0);
    check_out_mem("rst");
    check_in_mem("rst");
    rst = 1'b0;
    step();
    check("post_rst_net_rst", 32'(net_rst), 32'd0);

    // 1: basic XOR-style run
    host_load(0, 8'sd64);
    host_load(1, 8'sd0);
    begin_run();
    read_inputs();
    out_write(0, 8'sd63, 1'b1);
    finish_ok("xor");

    // Writes seen while idle are not captured
    out_write(0, DW'($urandom), 1'b0);
    check("idle_cap_cnt", 32'(out_cnt), 32'(cnt_ref));
    check_out_mem("idle_cap");

    // 2: timeout, err exactly TO cycles after entering COMPUTE
    begin_run();
    read_inputs();
    for (int i = 0; i < TO - 1; i++) step();
    check("to_err_early", 32'(err), 32'd0);
    check("to_req_early", 32'(net_req), 32'd1);
    step();
    check("to_err", 32'(err), 32'd1);
    check("to_done", 32'(done), 32'd0);
    check("to_req_low", 32'(net_req), 32'd0);
    check("to_busy", 32'(busy), 32'd0);
    step();
    check("to_err_level", 32'(err), 32'd1);

    // 3: ack in the same cycle as the last timeout count
    begin_run();
    read_inputs();
    for (int i = 0; i < TO - 1; i++) step();
    finish_ok("ack_edge");

    // 4: host write and start while busy are ignored
    begin_run();
    host_we = 1'b1; host_waddr = '0; host_wdata = -8'sd5; start = 1'b1;
    step();
    host_we = 1'b0; start = 1'b0;
    check("busy_no_nrst", 32'(net_rst), 32'd0);
    check("busy_still_fill", 32'(net_fill), 32'd1);
    read_inputs();

    // 5: out-of-range output write dropped; count saturates at N_OUT
    out_write(1, DW'($urandom), 1'b1);
    check("oor_cnt", 32'(out_cnt), 32'd0);
    check_out_mem("oor");
    out_write(0, DW'($urandom), 1'b1);
    out_write(0, DW'($urandom), 1'b1);
    check("sat_cnt", 32'(out_cnt), 32'(NO));
    finish_ok("busy_oor");

    // 6: reset mid-COMPUTE, then rerun
    host_load(0, DW'($urandom));
    host_load(1, DW'($urandom));
    begin_run();
    read_inputs();
    out_write(0, DW'($urandom), 1'b1);
    step();
    rst = 1'b1;
    step();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_req", 32'(net_req), 32'd0);
    check("mid_rst_cnt", 32'(out_cnt), 32'd0);
    check("mid_rst_net_rst", 32'(net_rst), 32'd1);
    rst = 1'b0;
    step();
    clear_model();
    check("after_rst_net_rst", 32'(net_rst), 32'd0);
    check("after_rst_done", 32'(done), 32'd0);
    check_out_mem("after_rst");
    check_in_mem("after_rst");

    for (int r = 0; r < 4; r++) random_run(r);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nn_io_host.md
Name: nn_io_host

Overview:
- Host-side counterpart of the generated neural-network top's serial I/O protocol.
- Owns the input vector register file:
  - answers the network's input read-trigger/address requests with data;
  - drives `fill`, `req` and a network-local reset.
- Captures the network's output write pulses (valid/address/data) into an output register file and reports completion or timeout.
- Sits between a simple host load/readback port and one network instance.

Parameters:
- DATA_W, 8, signed sample width (fixed-point activations).
- N_IN, 2, number of network inputs.
- N_OUT, 1, number of network outputs.
- IN_AW, 1, input address width; must satisfy 2**IN_AW >= N_IN.
- OUT_AW, 1, output address width; must satisfy 2**OUT_AW >= N_OUT.
- TIMEOUT, 1024, maximum cycles in COMPUTE before error.

Ports:
- clk  in  1  single clock; network runs on the same clock.
- rst  in  1  synchronous active-high reset.
- host_we  in  1  write input sample.
- host_waddr  in  IN_AW  input slot.
- host_wdata  in  DATA_W  signed sample.
- host_raddr  in  OUT_AW  result slot to read.
- host_rdata  out  DATA_W  combinational result read.
- start  in  1  single-cycle run request.
- busy  out  1  high in NRST/FILL/COMPUTE.
- done  out  1  level; run completed.
- err  out  1  level; run timed out.
- out_cnt  out  OUT_AW+1  output writes captured in the current run.
- net_rst  out  1  network reset.
- net_fill  out  1  request input fill.
- net_req  out  1  start computation.
- net_ack_fill  in  1  network finished reading inputs.
- net_ack  in  1  network finished writing outputs.
- net_in_trig  in  1  network input read trigger.
- net_in_addr  in  IN_AW  network input read address.
- net_in_data  out  DATA_W  combinational answer to the input read.
- net_out_trig  in  1  network output write pulse.
- net_out_addr  in  OUT_AW  output write address.
- net_out_data  in  DATA_W  output write data.

Behaviour:
- All state is registered on the rising edge of clk; rst is synchronous and active-high.
- Reset values:
  - state=IDLE, done=0, err=0, out_cnt=0;
  - net_fill=0, net_req=0, net_rst=1 (held while rst is high);
  - timeout counter=0;
  - both register files cleared to 0.
- net_in_data = in_mem[net_in_addr], combinational, so data is valid in the same cycle the trigger is seen. The network samples it at the next edge.
  - net_in_addr >= N_IN returns 0.
- States and transitions:
  - IDLE -> NRST when start=1.
  - DONE or ERR -> NRST when start=1. In NRST, done, err and out_cnt are cleared.
  - NRST: net_rst=1 for exactly one cycle; unconditional -> FILL.
  - FILL: net_fill=1; when net_ack_fill=1 -> COMPUTE. net_fill drops on the next cycle (one-cycle overlap with the ack is legal).
  - COMPUTE:
    - net_req=1 (level); the counter increments every cycle.
    - If net_ack=1 -> DONE, with net_req=0.
    - Otherwise, if the counter reaches TIMEOUT-1 -> ERR, with net_req=0.
    - net_ack has priority over the timeout in the same cycle.
  - DONE: done=1 (level) until the next start or rst.
  - ERR: err=1 (level) until the next start or rst.
- Output capture:
  - On net_out_trig=1 with net_out_addr < N_OUT: out_mem[net_out_addr] <= net_out_data, and out_cnt increments, saturating at N_OUT.
  - An out-of-range address is dropped and out_cnt is unchanged.
  - Capture is active in FILL and COMPUTE only; captures in other states are ignored.
- host_we is accepted only when busy=0; otherwise it is silently dropped.
- start while busy=1 is ignored.
- host_rdata = out_mem[host_raddr]; an out-of-range address returns 0.
- rst asserted mid-run returns the block to IDLE with all reset values. Register contents are cleared.

Decomposition:
- Package nn_io_pkg holds:
  - state enum (IDLE, NRST, FILL, COMPUTE, DONE, ERR);
  - default DATA_W;
  - a clog2 helper for counter width.
- Sub-module nn_io_regfile: parameterised DEPTH/DATA_W, one synchronous write port, one combinational read port, synchronous clear. Instantiated twice (input and output).

Test Plan:
1. Basic XOR run.
   - Stimulus: load in[0]=8'sd64, in[1]=8'sd0; start; the network model reads addresses 0 then 1, acks fill, then pulses an output write at address 0 with data 8'sd63 and asserts net_ack.
   - Required: net_rst high exactly 1 cycle; net_in_data=64 then 0 in the trigger cycles; done=1, err=0, out_cnt=1, host_rdata(0)=63.
2. Timeout.
   - Stimulus: TIMEOUT=16; the model never asserts net_ack.
   - Required: err=1 exactly 16 cycles after entering COMPUTE; net_req=0 afterwards; done=0.
3. Ack at the timeout boundary.
   - Stimulus: net_ack arrives in the same cycle the counter hits TIMEOUT-1.
   - Required: DONE, not ERR.
4. Busy rejection.
   - Stimulus: host_we to in[0]=-8'sd5 and a second start while in FILL.
   - Required: in[0] unchanged; no extra NRST pulse.
5. Out-of-range output write.
   - Stimulus: net_out_trig with net_out_addr=1 (N_OUT=1).
   - Required: out_cnt stays 0; out_mem unchanged.
6. Reset and rerun.
   - Stimulus: rst mid-COMPUTE, then start again.
   - Required: IDLE with out_cnt=0 and both memories 0; the rerun completes normally with a fresh net_rst pulse.
